dpram_byte_reader: RTL and testbench
====================================

# dpram_byte_reader

Read-side engine for the LED frame buffer. A writer fills the dual-port RAM through its byte-wide port A, 8 bits wide with an 11-bit address. This block owns port B, 32 bits wide with a 9-bit address, and turns a window of 32-bit words back into an ordered byte stream under a valid/ready handshake. It feeds the cube scan/PWM logic and replaces ad-hoc per-consumer address counters on port B.

## Interface
Parameters:
- `ADDR_W`, default 9: port-B word address width.
- `LEN_W`, default 10: width of the word-count input. It must hold 2^ADDR_W.

Ports:
- `clk` in 1: single clock. It also clocks RAM port B (`clkb` tied to `clk`).
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle request to begin a transfer. Sampled only in IDLE.
- `base` in ADDR_W: first word address. Sampled with `start`.
- `len` in LEN_W: number of words. Sampled with `start`. A value of 0 is treated as a no-op.
- `addrb` out ADDR_W: RAM port-B address. Registered.
- `dob` in 32: RAM port-B data. Valid one `clk` after `addrb` changes (registered read).
- `out_data` out 8: stream byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts. A byte transfers when `out_valid && out_ready`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last byte of a pass is accepted.

## Operation
States:
- **IDLE:** waits for `start`.
- **PRIME:** the first word is being fetched (2 cycles).
- **SEND:** bytes are streaming.
- **FLUSH:** the last word is streaming and no fetch is outstanding.

Transitions:
- IDLE → PRIME on `start` with `len != 0`.
  - `start` with `len == 0`: stay in IDLE, pulse `done` the next cycle.
- PRIME → SEND once the first word is captured into `cur_word`.
- SEND → FLUSH when the word being prefetched is the last one.
- FLUSH → IDLE when byte 3 of the last word is accepted.

Byte order is little-endian and mirrors the port-A write order:
- Word W, byte k (k = 0..3) is `dob[8k+7:8k]`.
- That byte corresponds to port-A address {W, k[1:0]}.
- Example: port-A writes 0x21, 0x43, 0x65, 0x87 to addresses 0..3 give word 0 = 0x87654321. The stream is 21, 43, 65, 87.

Prefetch:
- While streaming `cur_word`, `addrb` already points at the next word.
- The returned `dob` is captured once into `nxt_word` and `nxt_vld` is set.
- When byte 3 is accepted:
  - `cur_word` ← `nxt_word`.
  - The byte index goes to 0.
  - `addrb` advances.

Address arithmetic:
- Addresses advance modulo 2^ADDR_W, so they wrap from 511 to 0.
- `len == 2^ADDR_W` covers the whole RAM exactly once.

Backpressure:
- `out_data` and `out_valid` hold stable while `out_ready` is low.
- `out_valid` never deasserts without an acceptance, except on reset.

`start` received while `busy` is ignored, with no effect on the transfer in progress.

Reset:
- `rst_n` low at any time, including mid-stream, forces IDLE immediately.
- Outputs go to `addrb = 0`, `out_data = 0`, `out_valid = 0`, `busy = 0`, `done = 0`.
- `nxt_vld` and the byte index are cleared.
- No partial word resumes after reset.

## Timing
- `start` sampled high at edge t → `addrb = base` after t+1 → `dob` captured at t+2 → `out_valid = 1` after t+3. First-byte latency is 3 cycles.
- With `out_ready` held high, throughput is 1 byte per cycle sustained across word boundaries with no bubbles. A pass of N words occupies exactly 4N cycles of `out_valid`.
- `done` is high in the cycle after the final acceptance. `busy` falls in that same cycle.
- `addrb` changes only on a byte-3 acceptance or on a PRIME entry. This keeps RAM reads to one per word.

## Configuration
- `DPRAM_BYTE_READER_LOOP_EN` defined:
  - After the last word, the address wraps back to `base` and prefetch continues.
  - The FLUSH state is unused and the stream is continuous.
  - `done` pulses at the end of each pass.
  - Only reset ends a transfer.
- Macro undefined: single pass as described above.

## Structure
- Shared package `farbborg_pkg` holds:
  - the state enum (IDLE, PRIME, SEND, FLUSH),
  - `FB_ADDR_W = 9`,
  - `FB_BYTES_PER_WORD = 4`.
- One sub-module, `word_unpacker`:
  - holds `cur_word`, the 2-bit byte index, `out_data` and `out_valid`,
  - has a load strobe and handshake ports,
  - raises a `last_byte` flag back to the FSM.

## Test plan
- **Basic pass:** preload words 0..1 = 0x87654321, 0x87654321. Pulse `start` with base=0, len=2, `out_ready` held at 1. Required: bytes 21 43 65 87 21 43 65 87 on consecutive cycles, first byte valid 3 cycles after `start`, `done` once.
- **Backpressure:** same data with `out_ready` toggled 1,0,0,1 repeatedly. Required: every byte is held stable while stalled, with no drops and no duplicates.
- **Wrap:** base=510, len=4. Required: `addrb` sequence 510, 511, 0, 1.
- **len=0 and busy start:** `start` with len=0 gives no `out_valid` and a `done` pulse next cycle. A second `start` during a transfer is ignored.
- **Reset mid-stream:** assert `rst_n` = 0 after byte 5. Required: all outputs 0 immediately. A new `start` then replays from byte 0.
- **Loop mode (`DPRAM_BYTE_READER_LOOP_EN`):** base=10, len=1, word=0xDDCCBBAA. Required: stream AA BB CC DD repeating with no gaps, and `done` every 4 cycles.

Source files
------------

// File: rtl/farbborg_pkg.sv
// Shared types and constants for the LED frame-buffer read path.
package farbborg_pkg;

    localparam int unsigned FB_ADDR_W         = 9;
    localparam int unsigned FB_BYTES_PER_WORD = 4;
    localparam int unsigned FB_BYTE_W         = 8;
    localparam int unsigned FB_WORD_W         = FB_BYTES_PER_WORD * FB_BYTE_W;
    localparam int unsigned FB_BYTE_IDX_W     = $clog2(FB_BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_SEND,
        ST_FLUSH
    } fb_state_t;

    // Little-endian byte select: byte k lives at bits [8k+7:8k].
    function automatic logic [FB_BYTE_W-1:0] fb_byte(input logic [FB_WORD_W-1:0]     word,
                                                     input logic [FB_BYTE_IDX_W-1:0] idx);
        return word[{idx, 3'b000} +: FB_BYTE_W];
    endfunction

endpackage

// File: rtl/dpram_byte_reader_word_unpacker.sv
// Holds the current 32-bit word and streams it out one byte at a time under valid/ready.
module word_unpacker
    import farbborg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [FB_WORD_W-1:0] load_word,
    input  logic                 out_ready,
    output logic [FB_BYTE_W-1:0] out_data,
    output logic                 out_valid,
    output logic                 last_byte
);

    localparam logic [FB_BYTE_IDX_W-1:0] LAST_IDX = FB_BYTE_IDX_W'(FB_BYTES_PER_WORD - 1);

    logic [FB_WORD_W-1:0]     cur_word;
    logic [FB_BYTE_IDX_W-1:0] idx;
    logic [FB_BYTE_IDX_W-1:0] idx_inc;

    assign idx_inc = FB_BYTE_IDX_W'(idx + 1'b1);

    // A load always wins: it coincides with the byte-3 acceptance of the previous word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_word  <= '0;
            idx       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            last_byte <= 1'b0;
        end else if (load) begin
            cur_word  <= load_word;
            idx       <= '0;
            out_data  <= fb_byte(load_word, '0);
            out_valid <= 1'b1;
            last_byte <= 1'b0;
        end else if (out_valid && out_ready) begin
            if (last_byte) begin
                out_valid <= 1'b0;
                last_byte <= 1'b0;
            end else begin
                idx       <= idx_inc;
                out_data  <= fb_byte(cur_word, idx_inc);
                last_byte <= (idx_inc == LAST_IDX);
            end
        end
    end

endmodule

// File: rtl/dpram_byte_reader.sv
// Port-B read engine: streams a window of RAM words as little-endian bytes.
// Define DPRAM_BYTE_READER_LOOP_EN to replay the window continuously until reset.
module dpram_byte_reader
    import farbborg_pkg::*;
#(
    parameter int unsigned ADDR_W = FB_ADDR_W,
    parameter int unsigned LEN_W  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base,
    input  logic [LEN_W-1:0]     len,
    output logic [ADDR_W-1:0]    addrb,
    input  logic [FB_WORD_W-1:0] dob,
    output logic [FB_BYTE_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    fb_state_t            state;
    logic [ADDR_W-1:0]    base_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     fidx;
    logic [1:0]           pcnt;
    logic [1:0]           fcnt;
    logic [FB_WORD_W-1:0] nxt_word;
    logic                 nxt_vld;
`ifdef DPRAM_BYTE_READER_LOOP_EN
    logic [LEN_W-1:0]     cidx;
`endif

    logic                 last_byte;
    logic                 load;
    logic [FB_WORD_W-1:0] load_word;
    logic                 accept_last;
    logic [LEN_W-1:0]     len_last;
    logic                 fetch_last;
    logic [ADDR_W-1:0]    next_addr;
    logic [LEN_W-1:0]     next_fidx;

    assign accept_last = out_valid & out_ready & last_byte;
    assign len_last    = LEN_W'(len_q - 1'b1);
    // fidx is the position, within the pass, of the word addressed by addrb.
    assign fetch_last  = (fidx == len_last);
    assign next_addr   = fetch_last ? base_q : ADDR_W'(addrb + 1'b1);
    assign next_fidx   = fetch_last ? '0 : LEN_W'(fidx + 1'b1);
    assign load        = ((state == ST_PRIME) && (pcnt == 2'd2)) ||
                         ((state == ST_SEND) && accept_last);
    assign load_word   = (state == ST_PRIME) ? dob : nxt_word;

    // Control FSM with prefetch tracking; fcnt counts down the two-cycle RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            addrb    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            base_q   <= '0;
            len_q    <= '0;
            fidx     <= '0;
            pcnt     <= '0;
            fcnt     <= '0;
            nxt_word <= '0;
            nxt_vld  <= 1'b0;
`ifdef DPRAM_BYTE_READER_LOOP_EN
            cidx     <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (fcnt != 2'd0) fcnt <= fcnt - 2'd1;
            if ((fcnt == 2'd1) && !nxt_vld) begin
                nxt_word <= dob;
                nxt_vld  <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state   <= ST_PRIME;
                            busy    <= 1'b1;
                            base_q  <= base;
                            len_q   <= len;
                            fidx    <= '0;
                            pcnt    <= '0;
                            fcnt    <= '0;
                            nxt_vld <= 1'b0;
                        end
                    end
                end
                ST_PRIME: begin
                    pcnt <= pcnt + 2'd1;
                    if (pcnt == 2'd0) addrb <= base_q;
                    if (load) begin
`ifdef DPRAM_BYTE_READER_LOOP_EN
                        cidx    <= '0;
                        state   <= ST_SEND;
                        addrb   <= next_addr;
                        fidx    <= next_fidx;
                        fcnt    <= 2'd2;
                        nxt_vld <= 1'b0;
`else
                        if (fetch_last) begin
                            state <= ST_FLUSH;
                        end else begin
                            state   <= ST_SEND;
                            addrb   <= next_addr;
                            fidx    <= next_fidx;
                            fcnt    <= 2'd2;
                            nxt_vld <= 1'b0;
                        end
`endif
                    end
                end
                ST_SEND: begin
                    if (accept_last) begin
`ifdef DPRAM_BYTE_READER_LOOP_EN
                        done    <= (cidx == len_last);
                        cidx    <= (cidx == len_last) ? '0 : LEN_W'(cidx + 1'b1);
                        addrb   <= next_addr;
                        fidx    <= next_fidx;
                        fcnt    <= 2'd2;
                        nxt_vld <= 1'b0;
`else
                        if (fetch_last) begin
                            state <= ST_FLUSH;
                        end else begin
                            addrb   <= next_addr;
                            fidx    <= next_fidx;
                            fcnt    <= 2'd2;
                            nxt_vld <= 1'b0;
                        end
`endif
                    end
                end
                ST_FLUSH: begin
                    if (accept_last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    word_unpacker u_unpack (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_word (load_word),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .last_byte (last_byte)
    );

endmodule

// File: tb/tb_dpram_byte_reader.sv
// Randomized self-checking bench for dpram_byte_reader against a byte-queue reference model.
module tb_dpram_byte_reader;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned LEN_W  = 10;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addrb;
    logic [31:0]       dob;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] addr_hist[$];
    int                n_checks = 0;
    int                n_fail   = 0;

    always #5 clk = ~clk;

    // Registered-read RAM port B.
    always @(posedge clk) dob <= mem[addrb];

    dpram_byte_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base      (base),
        .len       (len),
        .addrb     (addrb),
        .dob       (dob),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addrb"}, 32'(addrb), 32'd0);
        check({tag, "_data"},  32'(out_data), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
    endtask

    // mode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic run_pass(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l,
                            input int mode, input bit busy_start, input int reset_after);
        logic [7:0]  expq[$];
        logic [31:0] w;
        logic [7:0]  exp_b;
        logic        pv = 1'b0;
        logic        pr = 1'b0;
        logic [7:0]  pd = '0;
        int          first_v  = -1;
        int          last_acc = -1;
        int          done_i   = -1;
        int          n_acc    = 0;
        int          n_done   = 0;

        for (int k = 0; k < int'(l); k++) begin
            w = mem[(int'(b) + k) % DEPTH];
            for (int j = 0; j < 4; j++) expq.push_back(w[8*j +: 8]);
        end
        addr_hist.delete();

        @(negedge clk);
        start = 1'b1; base = b; len = l; out_ready = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy_start && i == 6) begin
                start = 1'b1;
                base  = ADDR_W'(b + 9'd100);
                len   = LEN_W'(3);
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (i % 4 == 0) || (i % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (i >= 1 && busy && (addr_hist.size() == 0 || addr_hist[$] != addrb))
                addr_hist.push_back(addrb);
            if (pv && !pr) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data",  32'(out_data), 32'(pd));
            end
            if (out_valid && first_v < 0) first_v = i;
            if (out_valid && out_ready) begin
                exp_b = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
                check("byte", 32'(out_data), 32'(exp_b));
                last_acc = i;
                n_acc++;
                if (reset_after > 0 && n_acc == reset_after) begin
                    @(posedge clk);
                    #1 rst_n = 1'b0;
                    #1 check_idle_outputs("midreset");
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
            end
            if (done) begin
                n_done++;
                if (done_i < 0) done_i = i;
                check("busy_at_done", 32'(busy), 32'd0);
            end
            pv = out_valid; pr = out_ready; pd = out_data;
            if (done_i >= 0 && i >= done_i + 2) break;
        end

        check("done_timing", 32'(done_i), 32'(last_acc + 1));
        check("done_count",  32'(n_done), 32'd1);
        check("bytes_left",  32'(expq.size()), 32'd0);
        check("valid_after", 32'(out_valid), 32'd0);
        if (mode == 0) begin
            check("first_latency", 32'(first_v), 32'd3);
            check("no_bubbles", 32'(last_acc - first_v + 1), 32'(4 * int'(l)));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base = '0; len = '0; out_ready = 1'b0;
        for (int a = 0; a < int'(DEPTH); a++) mem[a] = $urandom;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

`ifdef DPRAM_BYTE_READER_LOOP_EN
        mem[10] = 32'hDDCCBBAA;
        @(negedge clk);
        start = 1'b1; base = ADDR_W'(10); len = LEN_W'(1); out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] lw;
            @(negedge clk);
            start = 1'b0;
            #1;
            lw = 32'hDDCCBBAA;
            if (i >= 3) begin
                check("loop_valid", 32'(out_valid), 32'd1);
                check("loop_byte", 32'(out_data), 32'(lw[8*((i-3)%4) +: 8]));
            end
            check("loop_done", 32'(done), 32'((i >= 7) && ((i - 3) % 4 == 0)));
        end
`else
        // Basic pass
        mem[0] = 32'h87654321; mem[1] = 32'h87654321;
        run_pass(ADDR_W'(0), LEN_W'(2), 0, 1'b0, -1);

        // Backpressure
        run_pass(ADDR_W'(0), LEN_W'(2), 1, 1'b0, -1);

        // Wrap around the top of the address space
        run_pass(ADDR_W'(510), LEN_W'(4), 0, 1'b0, -1);
        check("wrap_nhist", 32'(addr_hist.size()), 32'd4);
        if (addr_hist.size() == 4) begin
            check("wrap_a0", 32'(addr_hist[0]), 32'd510);
            check("wrap_a1", 32'(addr_hist[1]), 32'd511);
            check("wrap_a2", 32'(addr_hist[2]), 32'd0);
            check("wrap_a3", 32'(addr_hist[3]), 32'd1);
        end

        // Zero-length request
        @(negedge clk);
        start = 1'b1; base = ADDR_W'(7); len = '0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("len0_done",  32'(done), 32'd1);
        check("len0_valid", 32'(out_valid), 32'd0);
        check("len0_busy",  32'(busy), 32'd0);
        @(negedge clk);
        #1;
        check("len0_done_clr", 32'(done), 32'd0);
        check("len0_valid2",   32'(out_valid), 32'd0);

        // Start while busy is ignored
        run_pass(ADDR_W'(20), LEN_W'(3), 0, 1'b1, -1);

        // Randomized windows and ready patterns
        for (int r = 0; r < 6; r++)
            run_pass(ADDR_W'($urandom_range(0, DEPTH - 1)), LEN_W'($urandom_range(1, 6)),
                     2, 1'b0, -1);

        // Whole RAM exactly once
        run_pass(ADDR_W'($urandom_range(0, DEPTH - 1)), LEN_W'(DEPTH), 0, 1'b0, -1);

        // Reset mid-stream, then replay from byte 0
        run_pass(ADDR_W'(0), LEN_W'(2), 0, 1'b0, 5);
        run_pass(ADDR_W'(0), LEN_W'(2), 0, 1'b0, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
